pwm_array: RTL and testbench
============================

Name: pwm_array

Overview:
- Multi-channel successor to the single-channel PWM cell.
- Holds NCH double-buffered duty registers and an internal period counter, and generates NCH pulse-width outputs.
- Each output goes high when a period starts and drops after the channel's programmed number of cycles.
- Sits between the line/data loader (write port, start pulse) and the output driver pins; supports one-shot and continuous periods.

Parameters:
- DWIDTH, 8, duty and counter width; period = 2^DWIDTH clock cycles.
- NCH, 4, number of PWM channels (>=1).
- CHW, $clog2(NCH) (min 1), width of the channel-select field.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- wr_en  in  1  write strobe for the shadow duty register.
- wr_ch  in  CHW  channel index for the write.
- wr_data  in  DWIDTH  duty value (high-time in cycles).
- start  in  1  one-cycle request to begin a PWM period.
- cont  in  1  1 = restart automatically at period end; 0 = one-shot.
- out  out  NCH  PWM outputs, bit i = channel i.
- busy  out  1  high while a period is running.
- period_done  out  1  one-cycle pulse on the last cycle of each period.
- cnt  out  DWIDTH  current period counter value.

Behaviour:
- Reset (rst_n low, async): shadow[], active[], cnt, out, busy and period_done all go to 0; state = IDLE. Applies mid-period too; the period aborts immediately.
- Shadow write: on an edge with wr_en=1 and wr_ch<NCH, shadow[wr_ch] <= wr_data. wr_ch>=NCH is ignored. Writes never touch active[] directly.
- Reload: copies all shadow[] into active[] in one edge. It samples shadow contents from before that edge, so a write on the reload edge takes effect in the following period.
- State IDLE:
  - busy=0, out=0, cnt holds 0.
  - start=1 triggers a reload edge: cnt<=0; out[i] <= (shadow[i]!=0); busy<=1; state -> RUN.
  - Outputs are visible the cycle after start is sampled.
- State RUN, each edge:
  - cnt <= cnt+1, wrapping 2^DWIDTH-1 -> 0.
  - out[i] <= 0 on the edge where cnt == active[i]-1 and active[i]!=0.
  - Channel i is therefore high for exactly active[i] cycles. Value 0 gives 0 cycles (never rises). Max value 2^DWIDTH-1 gives low for 1 cycle at period end.
  - start during RUN is ignored, with no queuing.
- Period end: cnt == 2^DWIDTH-1 drives period_done=1 for that cycle. On that edge:
  - cont=1: reload, cnt<=0, out[i] <= (shadow[i]!=0), stay in RUN. There is no gap cycle between periods.
  - cont=0: out<=0, busy<=0, cnt<=0, state -> IDLE.
  - cont is sampled only at period end; start on this edge is ignored.
- Comparison is exact equality; a channel whose out already fell stays low until the next reload.
- All outputs are registered; no combinational path from inputs to out.

Optional Feature:
- Macro PWM_POLARITY_EN.
- When defined: adds input port pol [NCH] and register pol_q; pol_q reloads together with active[].
  - out[i] = registered PWM level XOR pol_q[i].
  - In IDLE and reset, out[i] = pol_q[i], which is 0 after reset.
- When undefined: no pol port; outputs are active-high exactly as described above.

Test Plan (DWIDTH=8, NCH=4):
- Reset then idle: rst_n=0 mid-RUN with out=4'b1111 -> out, busy, cnt go to 0 asynchronously; after release and no start, everything stays 0.
- One-shot duties: write shadow {0:0, 1:1, 2:128, 3:255}, start, cont=0 ->
  - ch0 never high; ch1 high 1 cycle; ch2 high 128 cycles; ch3 high 255 cycles.
  - period_done pulses once at cnt=255; busy falls the cycle after.
- Continuous with mid-period write: cont=1, ch0=10; write ch0=20 at cnt=50 -> current period keeps 10 high cycles; next period starts with no gap and has 20 high cycles.
- Write on reload edge: cont=1, write ch1=77 exactly at the cnt=255 edge -> next period uses the old value; the period after uses 77.
- Start while busy and bad channel: start pulses at cnt=30, plus write with wr_ch=5 (CHW=2 wraps, so use NCH=3 variant with wr_ch=3) -> period length unchanged at 256 cycles; no shadow register altered.
- PWM_POLARITY_EN: pol=4'b0101, duties all 4 -> ch0 and ch2 low for 4 cycles then high; ch1 and ch3 high for 4 cycles; idle levels 1,0,1,0.

Source files
------------

// File: rtl/pwm_array_if.sv
// Bus bundle for pwm_array: shadow write port, start/cont controls and PWM status.
// The pol field exists only when PWM_POLARITY_EN is defined.
interface pwm_array_if #(
  parameter int DWIDTH = 8,
  parameter int NCH    = 4,
  parameter int CHW    = (NCH > 1) ? $clog2(NCH) : 1
);
  logic              wr_en;
  logic [CHW-1:0]    wr_ch;
  logic [DWIDTH-1:0] wr_data;
  logic              start;
  logic              cont;
`ifdef PWM_POLARITY_EN
  logic [NCH-1:0]    pol;
`endif
  logic [NCH-1:0]    out;
  logic              busy;
  logic              period_done;
  logic [DWIDTH-1:0] cnt;

  modport master (
    output wr_en, wr_ch, wr_data, start, cont,
`ifdef PWM_POLARITY_EN
    output pol,
`endif
    input  out, busy, period_done, cnt
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, start, cont,
`ifdef PWM_POLARITY_EN
    input  pol,
`endif
    output out, busy, period_done, cnt
  );
endinterface

// File: rtl/pwm_array.sv
// NCH-channel PWM with double-buffered duty registers and a shared 2^DWIDTH-cycle period counter.
// Optional output polarity inversion is enabled by defining PWM_POLARITY_EN.
module pwm_array #(
  parameter int DWIDTH = 8,
  parameter int NCH    = 4,
  parameter int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input logic       clk,
  input logic       rst_n,
  pwm_array_if.slave bus
);
  localparam logic [DWIDTH-1:0] CNT_MAX = {DWIDTH{1'b1}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]    lvl;
  logic              at_end;
  logic              reload;
  logic              stop;
  logic              busy;
  logic              period_done;

  assign at_end = (state_q == RUN) && (cnt_q == CNT_MAX);
  assign reload = ((state_q == IDLE) && bus.start) || (at_end && bus.cont);
  assign stop   = at_end && !bus.cont;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter wraps to 0 on its own at period end, which covers both restart and stop.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == RUN);
    period_done = at_end;
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [DWIDTH-1:0] shadow_q;
      logic [DWIDTH-1:0] active_q;
      logic              pwm_q;

      // Reload reads shadow_q before this edge's write lands, so a coincident write waits a period.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_q <= '0;
          active_q <= '0;
          pwm_q    <= 1'b0;
        end else begin
          if (bus.wr_en && (bus.wr_ch == CHW'(gi))) shadow_q <= bus.wr_data;
          if (reload) begin
            active_q <= shadow_q;
            pwm_q    <= (shadow_q != '0);
          end else if (stop) begin
            pwm_q <= 1'b0;
          end else if ((state_q == RUN) && (active_q != '0) &&
                       (cnt_q == active_q - 1'b1)) begin
            pwm_q <= 1'b0;
          end
        end
      end

      assign lvl[gi] = pwm_q;
    end
  endgenerate

`ifdef PWM_POLARITY_EN
  logic [NCH-1:0] pol_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pol_q <= '0;
    else if (reload) pol_q <= bus.pol;
  end

  assign bus.out = lvl ^ pol_q;
`else
  assign bus.out = lvl;
`endif

  assign bus.busy        = busy;
  assign bus.period_done = period_done;
  assign bus.cnt         = cnt_q;
endmodule

// File: tb/tb_pwm_array.sv
// Directed bench for pwm_array: 4-channel main instance plus a 3-channel instance for out-of-range writes.
module tb_pwm_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pwm_array_if #(.DWIDTH(8), .NCH(4)) bus4 ();
  pwm_array_if #(.DWIDTH(8), .NCH(3)) bus3 ();

  pwm_array #(.DWIDTH(8), .NCH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  pwm_array #(.DWIDTH(8), .NCH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  task automatic wr4(input logic [1:0] ch, input logic [7:0] data);
    @(negedge clk);
    bus4.wr_en = 1'b1; bus4.wr_ch = ch; bus4.wr_data = data;
    @(negedge clk);
    bus4.wr_en = 1'b0;
  endtask

  // Pulse start; returns at the negedge where the first RUN cycle (cnt=0) is visible.
  task automatic start4(input logic c);
    @(negedge clk);
    bus4.start = 1'b1; bus4.cont = c;
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  task automatic test_reset;
    wr4(0, 8'd255); wr4(1, 8'd255); wr4(2, 8'd255); wr4(3, 8'd255);
    start4(1'b0);
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus4.out !== 4'b1111 || bus4.busy !== 1'b1 || bus4.cnt !== 8'd5) begin
      n_fail++;
      $display("FAIL reset_prerun: out=%b busy=%b cnt=%0d, required out=1111 busy=1 cnt=5", bus4.out, bus4.busy, bus4.cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus4.out !== 4'b0000 || bus4.busy !== 1'b0 || bus4.cnt !== 8'd0 || bus4.period_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: out=%b busy=%b cnt=%0d pd=%b, required all 0", bus4.out, bus4.busy, bus4.cnt, bus4.period_done);
    end
    $display("reset asserted mid-run: out=%b busy=%b cnt=%0d", bus4.out, bus4.busy, bus4.cnt);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus4.out !== 4'b0000 || bus4.busy !== 1'b0 || bus4.cnt !== 8'd0 || bus4.period_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: out=%b busy=%b cnt=%0d pd=%b, required all 0", i, bus4.out, bus4.busy, bus4.cnt, bus4.period_done);
      end
    end
    $display("idle after reset release: out=%b busy=%b cnt=%0d", bus4.out, bus4.busy, bus4.cnt);
  endtask

  task automatic test_oneshot;
    int hi[4];
    int exp_hi[4] = '{0, 1, 128, 255};
    int pd_cnt = 0, pd_at = -1, bcnt = 0;
    for (int c = 0; c < 4; c++) hi[c] = 0;
    wr4(0, 8'd0); wr4(1, 8'd1); wr4(2, 8'd128); wr4(3, 8'd255);
    start4(1'b0);
    n_checks++;
    if (bus4.cnt !== 8'd0 || bus4.busy !== 1'b1 || bus4.out !== 4'b1110) begin
      n_fail++;
      $display("FAIL oneshot_first: cnt=%0d busy=%b out=%b, required cnt=0 busy=1 out=1110", bus4.cnt, bus4.busy, bus4.out);
    end
    for (int i = 0; i < 256; i++) begin
      for (int c = 0; c < 4; c++) if (bus4.out[c]) hi[c]++;
      if (bus4.busy) bcnt++;
      if (bus4.period_done) begin pd_cnt++; pd_at = int'(bus4.cnt); end
      @(negedge clk);
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (hi[c] !== exp_hi[c]) begin
        n_fail++;
        $display("FAIL oneshot_hi ch%0d: high %0d cycles, required %0d", c, hi[c], exp_hi[c]);
      end
    end
    n_checks++;
    if (pd_cnt !== 1 || pd_at !== 255 || bcnt !== 256) begin
      n_fail++;
      $display("FAIL oneshot_pd: pulses=%0d at cnt=%0d busy_cycles=%0d, required 1 at 255, 256", pd_cnt, pd_at, bcnt);
    end
    n_checks++;
    if (bus4.busy !== 1'b0 || bus4.out !== 4'b0000 || bus4.cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL oneshot_end: busy=%b out=%b cnt=%0d, required 0/0000/0", bus4.busy, bus4.out, bus4.cnt);
    end
    $display("oneshot: hi=%0d,%0d,%0d,%0d pd=%0d@%0d busy_cycles=%0d", hi[0], hi[1], hi[2], hi[3], pd_cnt, pd_at, bcnt);
  endtask

  task automatic test_continuous;
    int h0[2] = '{0, 0};
    int bcnt = 0;
    wr4(0, 8'd10);
    start4(1'b1);
    for (int i = 0; i < 512; i++) begin
      if (bus4.out[0]) h0[i/256]++;
      if (bus4.busy) bcnt++;
      if (i == 256) begin
        n_checks++;
        if (bus4.cnt !== 8'd0 || bus4.out[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL cont_no_gap: cnt=%0d out0=%b, required cnt=0 out0=1", bus4.cnt, bus4.out[0]);
        end
      end
      if (i == 50) begin bus4.wr_en = 1'b1; bus4.wr_ch = 2'd0; bus4.wr_data = 8'd20; end
      if (i == 51) bus4.wr_en = 1'b0;
      if (i == 300) bus4.cont = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (h0[0] !== 10 || h0[1] !== 20) begin
      n_fail++;
      $display("FAIL cont_duty: period1=%0d period2=%0d, required 10 and 20", h0[0], h0[1]);
    end
    n_checks++;
    if (bcnt !== 512 || bus4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_busy: busy_cycles=%0d busy_now=%b, required 512 and 0", bcnt, bus4.busy);
    end
    $display("continuous: ch0 high %0d then %0d, busy_cycles=%0d", h0[0], h0[1], bcnt);
  endtask

  task automatic test_reload_edge;
    int h1[3] = '{0, 0, 0};
    int pd_cnt = 0;
    start4(1'b1);
    for (int i = 0; i < 768; i++) begin
      if (bus4.out[1]) h1[i/256]++;
      if (bus4.period_done) pd_cnt++;
      if (i == 255) begin bus4.wr_en = 1'b1; bus4.wr_ch = 2'd1; bus4.wr_data = 8'd77; end
      if (i == 256) bus4.wr_en = 1'b0;
      if (i == 600) bus4.cont = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (h1[0] !== 1 || h1[1] !== 1 || h1[2] !== 77) begin
      n_fail++;
      $display("FAIL reload_edge: ch1 high %0d,%0d,%0d, required 1,1,77", h1[0], h1[1], h1[2]);
    end
    n_checks++;
    if (pd_cnt !== 3 || bus4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_pd: pulses=%0d busy=%b, required 3 and 0", pd_cnt, bus4.busy);
    end
    $display("reload edge write: ch1 high %0d,%0d,%0d pd=%0d", h1[0], h1[1], h1[2], pd_cnt);
  endtask

  task automatic test_busy_badch;
    int hi[2][3];
    int bcnt[2] = '{0, 0};
    int exp_hi[3] = '{5, 6, 7};
    for (int p = 0; p < 2; p++) for (int c = 0; c < 3; c++) hi[p][c] = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus3.wr_en = 1'b1; bus3.wr_ch = 2'(c); bus3.wr_data = 8'(exp_hi[c]);
    end
    @(negedge clk);
    bus3.wr_en = 1'b0;
    for (int p = 0; p < 2; p++) begin
      bus3.start = 1'b1; bus3.cont = 1'b0;
      @(negedge clk);
      bus3.start = 1'b0;
      for (int i = 0; i < 270; i++) begin
        for (int c = 0; c < 3; c++) if (bus3.out[c]) hi[p][c]++;
        if (bus3.busy) bcnt[p]++;
        if (p == 0 && i == 30) begin
          bus3.start = 1'b1; bus3.wr_en = 1'b1; bus3.wr_ch = 2'd3; bus3.wr_data = 8'd99;
        end
        if (p == 0 && i == 31) begin bus3.start = 1'b0; bus3.wr_en = 1'b0; end
        @(negedge clk);
      end
    end
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if (bcnt[p] !== 256) begin
        n_fail++;
        $display("FAIL badch_len period%0d: busy %0d cycles, required 256", p, bcnt[p]);
      end
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (hi[p][c] !== exp_hi[c]) begin
          n_fail++;
          $display("FAIL badch_hi period%0d ch%0d: high %0d, required %0d", p, c, hi[p][c], exp_hi[c]);
        end
      end
    end
    $display("start-while-busy/bad channel: busy %0d,%0d hi=%0d,%0d,%0d", bcnt[0], bcnt[1], hi[1][0], hi[1][1], hi[1][2]);
  endtask

`ifdef PWM_POLARITY_EN
  task automatic test_polarity;
    int hi[4];
    int exp_hi[4] = '{252, 4, 252, 4};
    for (int c = 0; c < 4; c++) hi[c] = 0;
    bus4.pol = 4'b0101;
    wr4(0, 8'd4); wr4(1, 8'd4); wr4(2, 8'd4); wr4(3, 8'd4);
    start4(1'b0);
    n_checks++;
    if (bus4.out !== 4'b1010) begin
      n_fail++;
      $display("FAIL pol_first: out=%b, required 1010", bus4.out);
    end
    for (int i = 0; i < 256; i++) begin
      for (int c = 0; c < 4; c++) if (bus4.out[c]) hi[c]++;
      @(negedge clk);
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (hi[c] !== exp_hi[c]) begin
        n_fail++;
        $display("FAIL pol_hi ch%0d: high %0d, required %0d", c, hi[c], exp_hi[c]);
      end
    end
    n_checks++;
    if (bus4.out !== 4'b0101 || bus4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pol_idle: out=%b busy=%b, required 0101 and 0", bus4.out, bus4.busy);
    end
    $display("polarity: hi=%0d,%0d,%0d,%0d idle out=%b", hi[0], hi[1], hi[2], hi[3], bus4.out);
  endtask
`endif

  initial begin
    bus4.wr_en = 1'b0; bus4.wr_ch = '0; bus4.wr_data = '0; bus4.start = 1'b0; bus4.cont = 1'b0;
    bus3.wr_en = 1'b0; bus3.wr_ch = '0; bus3.wr_data = '0; bus3.start = 1'b0; bus3.cont = 1'b0;
`ifdef PWM_POLARITY_EN
    bus4.pol = '0;
    bus3.pol = '0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_oneshot();
    test_continuous();
    test_reload_edge();
    test_busy_badch();
`ifdef PWM_POLARITY_EN
    test_polarity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
